// File: rtl/iram_pkg.sv
// Shared types for the instruction RAM controller.
// IRAM_PARITY_EN selects one extra even-parity bit per stored word.
package iram_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StIdle  = 1'b1
  } iram_state_e;

`ifdef IRAM_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif

endpackage

// File: rtl/iram_array.sv
// Plain 1r1w storage: synchronous write, registered read address, asynchronous array read.
module iram_array #(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [2**AddrW];
  logic [AddrW-1:0] raddr_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   raddr_q <= '0;
    else if (re_i) raddr_q <= raddr_i;
  end

  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/iram_ctl.sv
// Instruction RAM controller: clear sequencer, write-first forwarding, held read data.
// Define IRAM_PARITY_EN to store and check an even-parity bit per word.
module iram_ctl
  import iram_pkg::*;
#(
  parameter int unsigned       DWIDTH  = 8,
  parameter int unsigned       AWIDTH  = 8,
  parameter logic [DWIDTH-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] ram_radr,
  input  logic              ram_ren,
  output logic [DWIDTH-1:0] ram_rdata,
  output logic              ram_rvalid,
  input  logic [AWIDTH-1:0] ram_wadr,
  input  logic [DWIDTH-1:0] ram_wdata,
  input  logic              ram_wen,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop,
  output logic              par_err
);

  localparam int unsigned MemW = DWIDTH + ParBits;

  iram_state_e       state_q, state_d;
  logic [AWIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              byp_q, byp_d;
  logic [DWIDTH-1:0] fwd_q, fwd_d;
  logic [DWIDTH-1:0] hold_q;
  logic              wr_drop_q, wr_drop_d;

  logic              mem_we, mem_re;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wraw;
  logic [MemW-1:0]   mem_wdata, mem_rdata;
  logic [DWIDTH-1:0] rd_word;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rvalid_d  = 1'b0;
    byp_d     = byp_q;
    fwd_d     = fwd_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = ram_wadr;
    mem_wraw  = ram_wdata;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wraw  = CLR_VAL;
        clr_cnt_d = clr_cnt_q + AWIDTH'(1);
        wr_drop_d = ram_wen;
        if (clr_cnt_q == {AWIDTH{1'b1}}) state_d = StIdle;
      end
      StIdle: begin
        mem_we   = ram_wen;
        mem_re   = ram_ren;
        rvalid_d = ram_ren;
        if (ram_ren) begin
          byp_d = ram_wen && (ram_wadr == ram_radr);
          fwd_d = ram_wdata;
        end
        // Port traffic in this cycle still completes; clearing begins next cycle.
        if (clr_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

`ifdef IRAM_PARITY_EN
  assign mem_wdata = {^mem_wraw, mem_wraw};
  assign par_err   = rvalid_q && !byp_q && (^mem_rdata);
`else
  assign mem_wdata = mem_wraw;
  assign par_err   = 1'b0;
`endif

  iram_array #(
    .Width (MemW),
    .AddrW (AWIDTH)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (ram_radr),
    .rdata_o (mem_rdata)
  );

  // Output only moves after a valid read; otherwise the last result is held.
  assign rd_word    = byp_q ? fwd_q : mem_rdata[DWIDTH-1:0];
  assign ram_rdata  = rvalid_q ? rd_word : hold_q;
  assign ram_rvalid = rvalid_q;
  assign busy       = (state_q == StClear);
  assign wr_drop    = wr_drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      byp_q     <= 1'b0;
      fwd_q     <= '0;
      hold_q    <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid_q  <= rvalid_d;
      byp_q     <= byp_d;
      fwd_q     <= fwd_d;
      hold_q    <= ram_rdata;
      wr_drop_q <= wr_drop_d;
    end
  end

endmodule

// File: tb/tb_iram_ctl.sv
// Self-checking bench for iram_ctl (DWIDTH=8, AWIDTH=4, CLR_VAL=8'hA5).
module tb_iram_ctl;

  localparam logic [7:0] ClrVal = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ram_radr = '0;
  logic       ram_ren = 1'b0;
  logic [7:0] ram_rdata;
  logic       ram_rvalid;
  logic [3:0] ram_wadr = '0;
  logic [7:0] ram_wdata = '0;
  logic       ram_wen = 1'b0;
  logic       clr_req = 1'b0;
  logic       busy, wr_drop, par_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mdl_mem [16];
  logic [7:0] exp_rd;

  typedef struct {
    logic       ren;
    logic [3:0] radr;
    logic       wen;
    logic [3:0] wadr;
    logic [7:0] wdata;
    logic       rv;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [8];

  iram_ctl #(
    .DWIDTH  (8),
    .AWIDTH  (4),
    .CLR_VAL (ClrVal)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ram_radr   (ram_radr),
    .ram_ren    (ram_ren),
    .ram_rdata  (ram_rdata),
    .ram_rvalid (ram_rvalid),
    .ram_wadr   (ram_wadr),
    .ram_wdata  (ram_wdata),
    .ram_wen    (ram_wen),
    .clr_req    (clr_req),
    .busy       (busy),
    .wr_drop    (wr_drop),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ren, input logic [3:0] radr, input logic wen,
                       input logic [3:0] wadr, input logic [7:0] wdata);
    ram_ren   = ren;
    ram_radr  = radr;
    ram_wen   = wen;
    ram_wadr  = wadr;
    ram_wdata = wdata;
  endtask

  // Ticks until busy falls, starting from an already elapsed count.
  task automatic wait_idle(input int start, output int n);
    n = start;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic read_all(input string name);
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 4'(a), 1'b0, 4'd0, 8'd0);
      tick();
      chk({name, "_rvalid"}, 32'(ram_rvalid), 32'd1);
      chk({name, "_rdata"}, 32'(ram_rdata), 32'(mdl_mem[a]));
      exp_rd = mdl_mem[a];
    end
    drive(1'b0, 4'd0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic model_clear;
    for (int a = 0; a < 16; a++) mdl_mem[a] = ClrVal;
  endtask

  initial begin
    int n;
    tbl[0] = '{1'b0, 4'd0, 1'b1, 4'd5, 8'h3C, 1'b0, 8'hA5};
    tbl[1] = '{1'b1, 4'd5, 1'b0, 4'd0, 8'h00, 1'b1, 8'h3C};
    tbl[2] = '{1'b1, 4'd7, 1'b1, 4'd7, 8'h11, 1'b1, 8'h11};
    tbl[3] = '{1'b0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 8'h11};
    tbl[4] = '{1'b1, 4'd7, 1'b1, 4'd7, 8'h22, 1'b1, 8'h22};
    tbl[5] = '{1'b1, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1, 8'hA5};
    tbl[6] = '{1'b1, 4'd5, 1'b1, 4'd6, 8'h77, 1'b1, 8'h3C};
    tbl[7] = '{1'b1, 4'd6, 1'b0, 4'd0, 8'h00, 1'b1, 8'h77};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rvalid", 32'(ram_rvalid), 32'd0);
    chk("rst_rdata", 32'(ram_rdata), 32'd0);
    chk("rst_wr_drop", 32'(wr_drop), 32'd0);
    chk("rst_par_err", 32'(par_err), 32'd0);

    // Release reset: clear lasts exactly 16 cycles
    tick();
    rst_n = 1'b1;
    wait_idle(0, n);
    chk("init_clear_cycles", 32'(n), 32'd16);
    model_clear();
    exp_rd = 8'h00;
    read_all("init_read");

    // Directed table
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].ren, tbl[i].radr, tbl[i].wen, tbl[i].wadr, tbl[i].wdata);
      tick();
      chk($sformatf("tbl%0d_rvalid", i), 32'(ram_rvalid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_rdata", i), 32'(ram_rdata), 32'(tbl[i].rd));
      if (tbl[i].wen) mdl_mem[tbl[i].wadr] = tbl[i].wdata;
      exp_rd = tbl[i].rd;
    end

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      logic       ren, wen;
      logic [3:0] radr, wadr;
      logic [7:0] wdata;
      ren   = 1'($urandom_range(0, 1));
      wen   = 1'($urandom_range(0, 1));
      radr  = 4'($urandom_range(0, 15));
      wadr  = (i % 4 == 0) ? radr : 4'($urandom_range(0, 15));
      wdata = 8'($urandom);
      drive(ren, radr, wen, wadr, wdata);
      if (ren) exp_rd = (wen && wadr == radr) ? wdata : mdl_mem[radr];
      if (wen) mdl_mem[wadr] = wdata;
      tick();
      chk("rnd_rvalid", 32'(ram_rvalid), 32'(ren));
      chk("rnd_rdata", 32'(ram_rdata), 32'(exp_rd));
      chk("rnd_wr_drop", 32'(wr_drop), 32'd0);
      chk("rnd_par_err", 32'(par_err), 32'd0);
    end

    // Clear request together with a write-first read
    drive(1'b1, 4'd2, 1'b1, 4'd2, 8'h5A);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_same_rvalid", 32'(ram_rvalid), 32'd1);
    chk("clr_same_rdata", 32'(ram_rdata), 32'h5A);
    chk("clr_busy_rise", 32'(busy), 32'd1);
    drive(1'b1, 4'd3, 1'b1, 4'd3, 8'h99);
    tick();
    chk("busy_wr_drop", 32'(wr_drop), 32'd1);
    chk("busy_rvalid", 32'(ram_rvalid), 32'd0);
    chk("busy_rdata_hold", 32'(ram_rdata), 32'h5A);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 8'd0);
    tick();
    chk("busy_wr_drop_end", 32'(wr_drop), 32'd0);
    wait_idle(2, n);
    chk("req_clear_cycles", 32'(n), 32'd16);
    model_clear();
    read_all("post_clr_read");

    // Reset in the middle of a clear (clr_cnt = 9)
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_rdata", 32'(ram_rdata), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_idle(0, n);
    chk("midrst_clear_cycles", 32'(n), 32'd16);
    read_all("midrst_read");

`ifdef IRAM_PARITY_EN
    dut.u_array.mem_q[3] = dut.u_array.mem_q[3] ^ 9'h001;
    drive(1'b1, 4'd3, 1'b0, 4'd0, 8'd0);
    tick();
    chk("par_bad_rvalid", 32'(ram_rvalid), 32'd1);
    chk("par_bad_err", 32'(par_err), 32'd1);
    drive(1'b1, 4'd4, 1'b0, 4'd0, 8'd0);
    tick();
    chk("par_clean_err", 32'(par_err), 32'd0);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 8'd0);
    tick();
    chk("par_idle_err", 32'(par_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
